// File: rtl/regfile_wb_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : regfile_wb_arbiter_pkg
// Description : Shared register-file widths, enables and arbiter defaults.
// Revision    : 1.0 - initial release
// ============================================================================
package regfile_wb_arbiter_pkg;

    localparam int unsigned c_reg_bus_w    = 32;   // RegBus width
    localparam int unsigned c_reg_num_log2 = 5;    // RegAddrBus width
    localparam int unsigned c_starve_max   = 3;    // StarveMax default

    localparam logic c_write_enable  = 1'b1;
    localparam logic c_write_disable = 1'b0;
    localparam logic c_rst_enable    = 1'b1;

    localparam logic [c_reg_bus_w-1:0] c_zero_word = '0;

    typedef logic [c_reg_bus_w-1:0]    reg_bus_t;
    typedef logic [c_reg_num_log2-1:0] reg_addr_bus_t;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_S0   = 2'd1,
        GNT_S1   = 2'd2
    } grant_e;

    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_wb_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : regfile_wb_arbiter_if
// Description : Writeback sources, register-file write port and read-hazard
//               signals seen by the writeback arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface regfile_wb_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              s0_valid;
    logic [ADDR_W-1:0] s0_waddr;
    logic [DATA_W-1:0] s0_wdata;
    logic              s0_ready;

    logic              s1_valid;
    logic [ADDR_W-1:0] s1_waddr;
    logic [DATA_W-1:0] s1_wdata;
    logic              s1_ready;

    logic              rf_we;
    logic [ADDR_W-1:0] rf_waddr;
    logic [DATA_W-1:0] rf_wdata;

    logic              re1;
    logic [ADDR_W-1:0] raddr1;
    logic              re2;
    logic [ADDR_W-1:0] raddr2;
    logic              stall1;
    logic              stall2;

    modport slave (
        input  s0_valid, s0_waddr, s0_wdata,
        output s0_ready,
        input  s1_valid, s1_waddr, s1_wdata,
        output s1_ready,
        output rf_we, rf_waddr, rf_wdata,
        input  re1, raddr1, re2, raddr2,
        output stall1, stall2
    );

    modport master (
        output s0_valid, s0_waddr, s0_wdata,
        input  s0_ready,
        output s1_valid, s1_waddr, s1_wdata,
        input  s1_ready,
        input  rf_we, rf_waddr, rf_wdata,
        output re1, raddr1, re2, raddr2,
        input  stall1, stall2
    );

endinterface
`default_nettype wire

// File: rtl/regfile_wb_arbiter_hazard_cmp.sv
`default_nettype none
// ============================================================================
// Module      : wb_hazard_cmp
// Description : Per-read-port comparator flagging a read of a register that
//               still has a pending writeback at either source.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_hazard_cmp #(
    parameter int ADDR_W = 5
) (
    input  wire logic              re,
    input  wire logic [ADDR_W-1:0] raddr,
    input  wire logic              s0_valid,
    input  wire logic [ADDR_W-1:0] s0_waddr,
    input  wire logic              s1_valid,
    input  wire logic [ADDR_W-1:0] s1_waddr,
    output logic                   stall
);

    logic w_s0_match;
    logic w_s1_match;

    always_comb begin
        w_s0_match = s0_valid && (s0_waddr == raddr);
        w_s1_match = s1_valid && (s1_waddr == raddr);
        // x0 is hardwired, so reading it can never be a hazard
        stall      = re && (raddr != '0) && (w_s0_match || w_s1_match);
    end

endmodule
`default_nettype wire

// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : regfile_wb_arbiter
// Description : Arbitrates the single register-file write port between the
//               ALU (source 0) and load unit (source 1) with a starvation
//               guard, registers the write, and raises read-hazard stalls.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int DATA_W     = c_reg_bus_w,
    parameter int ADDR_W     = c_reg_num_log2,
    parameter int STARVE_MAX = c_starve_max
) (
    input  wire logic             clk,
    input  wire logic             rst,
    regfile_wb_arbiter_if.slave   bus
);

    localparam int unsigned        c_cnt_w   = cnt_width(STARVE_MAX);
    localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(STARVE_MAX);

    logic [c_cnt_w-1:0] starve_cnt_q;
    logic [c_cnt_w-1:0] starve_cnt_d;
    logic               rf_we_q;
    logic               rf_we_d;
    logic [ADDR_W-1:0]  rf_waddr_q;
    logic [ADDR_W-1:0]  rf_waddr_d;
    logic [DATA_W-1:0]  rf_wdata_q;
    logic [DATA_W-1:0]  rf_wdata_d;

    logic               w_rst_act;
    logic               w_starve_hit;
    logic               w_grant0;
    logic               w_grant1;
    grant_e             w_grant;
    logic [ADDR_W-1:0]  w_gnt_waddr;
    logic [DATA_W-1:0]  w_gnt_wdata;
    logic               w_hit1;
    logic               w_hit2;

    // Grants are gated by reset so nothing transfers while rst is high
    always_comb begin
        w_rst_act    = (rst == c_rst_enable);
        w_starve_hit = (starve_cnt_q == c_cnt_max);
        w_grant0     = !w_rst_act && bus.s0_valid && !(bus.s1_valid && w_starve_hit);
        w_grant1     = !w_rst_act && bus.s1_valid && !w_grant0;
        w_grant      = GNT_NONE;
        if (w_grant1) begin
            w_grant = GNT_S1;
        end else if (w_grant0) begin
            w_grant = GNT_S0;
        end
    end

    always_comb begin
        w_gnt_waddr = bus.s0_waddr;
        w_gnt_wdata = bus.s0_wdata;
        case (w_grant)
            GNT_S1: begin
                w_gnt_waddr = bus.s1_waddr;
                w_gnt_wdata = bus.s1_wdata;
            end
            default: begin
                w_gnt_waddr = bus.s0_waddr;
                w_gnt_wdata = bus.s0_wdata;
            end
        endcase
    end

    always_comb begin
        starve_cnt_d = starve_cnt_q;
        rf_we_d      = c_write_disable;
        rf_waddr_d   = rf_waddr_q;
        rf_wdata_d   = rf_wdata_q;
        if (w_rst_act) begin
            starve_cnt_d = '0;
            rf_waddr_d   = '0;
            rf_wdata_d   = DATA_W'(c_zero_word);
        end else begin
            if (bus.s1_valid && !w_grant1) begin
                if (starve_cnt_q != c_cnt_max) begin
                    starve_cnt_d = starve_cnt_q + 1'b1;
                end
            end else begin
                starve_cnt_d = '0;
            end
            if (w_grant != GNT_NONE) begin
                // x0 writes are accepted upstream but never reach the file
                rf_we_d    = (w_gnt_waddr != '0) ? c_write_enable : c_write_disable;
                rf_waddr_d = w_gnt_waddr;
                rf_wdata_d = w_gnt_wdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        starve_cnt_q <= starve_cnt_d;
        rf_we_q      <= rf_we_d;
        rf_waddr_q   <= rf_waddr_d;
        rf_wdata_q   <= rf_wdata_d;
    end

    wb_hazard_cmp #(
        .ADDR_W   (ADDR_W)
    ) u_hazard_cmp1 (
        .re       (bus.re1),
        .raddr    (bus.raddr1),
        .s0_valid (bus.s0_valid),
        .s0_waddr (bus.s0_waddr),
        .s1_valid (bus.s1_valid),
        .s1_waddr (bus.s1_waddr),
        .stall    (w_hit1)
    );

    wb_hazard_cmp #(
        .ADDR_W   (ADDR_W)
    ) u_hazard_cmp2 (
        .re       (bus.re2),
        .raddr    (bus.raddr2),
        .s0_valid (bus.s0_valid),
        .s0_waddr (bus.s0_waddr),
        .s1_valid (bus.s1_valid),
        .s1_waddr (bus.s1_waddr),
        .stall    (w_hit2)
    );

    assign bus.s0_ready = w_grant0;
    assign bus.s1_ready = w_grant1;
    assign bus.rf_we    = rf_we_q;
    assign bus.rf_waddr = rf_waddr_q;
    assign bus.rf_wdata = rf_wdata_q;
    assign bus.stall1   = !w_rst_act && w_hit1;
    assign bus.stall2   = !w_rst_act && w_hit2;

endmodule
`default_nettype wire

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the register file's single write port between two writeback requesters. Source 0 is the ALU/execute result and source 1 is the load unit.
- Fixed priority with a starvation guard, plus a registered write-port stage with 1-cycle latency.
- Generates read-hazard stall flags for the two read ports when a pending, not-yet-written writeback targets the register being read.
- Sits between the EX/MEM writeback sources and the register file; the decode stage consumes the stall flags.

Parameters:
- DATA_W, 32, register data width.
- ADDR_W, 5, register address width (32 registers).
- STARVE_MAX, 3, consecutive cycles source 1 may be denied before it gets priority; legal range 1..15.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- s0_valid  in  1  ALU writeback request.
- s0_waddr  in  ADDR_W  ALU destination register.
- s0_wdata  in  DATA_W  ALU result.
- s0_ready  out  1  ALU request accepted this cycle.
- s1_valid  in  1  load writeback request.
- s1_waddr  in  ADDR_W  load destination register.
- s1_wdata  in  DATA_W  load data.
- s1_ready  out  1  load request accepted this cycle.
- rf_we  out  1  register file write enable (registered).
- rf_waddr  out  ADDR_W  register file write address (registered).
- rf_wdata  out  DATA_W  register file write data (registered).
- re1  in  1  read port 1 enable.
- raddr1  in  ADDR_W  read port 1 address.
- re2  in  1  read port 2 enable.
- raddr2  in  ADDR_W  read port 2 address.
- stall1  out  1  read port 1 must stall (pending write to raddr1).
- stall2  out  1  read port 2 must stall (pending write to raddr2).

Behaviour:
- Handshake: a request transfers on a cycle where valid && ready.
  - A source holds valid, waddr and wdata stable until it is accepted.
  - ready is combinational from the valids and internal state only; it never depends on ready itself.
- Arbitration, at most one grant per cycle:
  - Default is source 0 first: grant0 = s0_valid && !(s1_valid && starve_hit); grant1 = s1_valid && !grant0.
  - starve_hit = (starve_cnt == STARVE_MAX).
- starve_cnt, width clog2(STARVE_MAX+1):
  - Increments when s1_valid && !grant1.
  - Clears to 0 when grant1, or when s1_valid is low.
  - Saturates at STARVE_MAX; it never wraps.
- Output stage, updated on every posedge:
  - rf_we <= (grant0 || grant1) && (granted waddr != 0).
  - rf_waddr and rf_wdata <= the granted source's fields.
  - Latency: a handshake in cycle N produces the register file write at edge N+1.
  - A write to x0 is accepted (ready high) but produces rf_we = 0.
- Hazard flags, combinational:
  - stallK = reK && raddrK != 0 && ((s0_valid && s0_waddr == raddrK) || (s1_valid && s1_waddr == raddrK)).
  - This includes a source being granted in the current cycle, because its data reaches the register file only next cycle.
  - The write currently on rf_we needs no stall; the register file's write-through bypass covers it.
- Simultaneous valids with the same waddr: the grant order defines the write order, and the later writer wins in the register file.
- Reset: while rst is high at a posedge, rf_we <= 0, rf_waddr <= 0, rf_wdata <= 0 and starve_cnt <= 0.
  - s0_ready, s1_ready, stall1 and stall2 are forced to 0 combinationally while rst is high, so no request transfers during reset.
  - Reset asserted mid-operation drops the in-flight output-stage write (rf_we is 0 after that edge); the sources retain their requests.
- Reset values: rf_we = 0, rf_waddr = 0, rf_wdata = 0, starve_cnt = 0.

Decomposition:
- Use the existing shared defines file for RegBus, RegAddrBus, WriteEnable/WriteDisable, RstEnable, ZeroWord and RegNumLog2.
- Add StarveMax as the default there.
- One natural sub-module: wb_hazard_cmp, the per-read-port address comparator, instantiated twice.

Test Plan:
- Reset hold: rst = 1 for 3 cycles with s0_valid = s1_valid = 1 -> both ready = 0 and rf_we = 0. After rst falls, s0 is granted first and rf_we = 1 at the next edge.
- Single source: s0_valid with waddr = 5, wdata = 0xDEADBEEF -> s0_ready = 1 the same cycle; one cycle later rf_we = 1, rf_waddr = 5, rf_wdata = 0xDEADBEEF.
- x0 write: s1_valid with waddr = 0, wdata = 0x1234 -> s1_ready = 1; next cycle rf_we = 0.
- Starvation: STARVE_MAX = 3, both valid continuously with s0 issuing new requests -> s0 is granted cycles 0-2, s1 is granted cycle 3, and starve_cnt returns to 0.
- Hazard: s1_valid with waddr = 7 held off by s0; re1 = 1, raddr1 = 7 -> stall1 = 1 until the cycle after s1 is accepted. raddr2 = 0 with s0_waddr = 0 -> stall2 = 0.
- Mid-op reset: grant s0 (waddr = 3), then assert rst at the next edge -> rf_we = 0 after that edge and no write to register 3 occurs.
